// File: rtl/ledstring_fb_streamer.sv
// ============================================================================
// ledstring_fb_streamer
//
// Purpose:
//   Upstream sequencer for an APA102 LED string serializer. A start request
//   walks the pixel framebuffer and sends three kinds of word over the
//   serializer's valid/ack interface, in this order:
//     - one start frame
//     - led_count pixel words
//     - (n >> 6) + 1 end frames
//   The module owns the framebuffer read port. That port is a synchronous RAM
//   with a 1-cycle read latency. busy/done report progress to the register block.
//
// Optional feature (compile-time macro LEDSTRING_AUTO_REFRESH_EN):
//   A free-running divider wraps every REFRESH_DIV cycles. A wrap that lands
//   while the block is idle starts a frame, using the live led_count/glo.
//   A wrap that lands while the block is busy is dropped. Without the macro,
//   frames start only on the start input.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle frame request (ignored unless idle)
//   led_count    pixels to send, 0..MAX_LEDS (values above are clamped)
//   glo          5-bit global brightness for pixel words
//   busy         high from accepted start until the done cycle
//   done         one-cycle pulse after the last end frame is acked
//   fb_rd_en     framebuffer read strobe
//   fb_rd_addr   framebuffer read address
//   fb_rd_data   {red,grn,blu}, valid the cycle after fb_rd_en
//   framing      0 = pixel word, 1 = framing word
//   se_frame     0 = start frame, 1 = end frame
//   dat_glo      pixel brightness
//   dat_red/grn/blu  pixel colour
//   valid        word request to serializer (registered)
//   ack          serializer accept pulse
// ============================================================================
module ledstring_fb_streamer #(
    parameter int          MAX_LEDS    = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [23:0] REFRESH_DIV = 24'd600000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   led_count,
    input  logic [4:0]        glo,
    output logic              busy,
    output logic              done,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [23:0]       fb_rd_data,
    output logic              framing,
    output logic              se_frame,
    output logic [4:0]        dat_glo,
    output logic [7:0]        dat_red,
    output logic [7:0]        dat_grn,
    output logic [7:0]        dat_blu,
    output logic              valid,
    input  logic              ack
);

    // The counters are one bit wider than the address, so that n == MAX_LEDS
    // can be represented and reached without wrapping.
    localparam int            CW    = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_N = CW'(MAX_LEDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SOF,
        S_SOF_W,
        S_FETCH,
        S_LOAD,
        S_PIX_W,
        S_EOF,
        S_EOF_W,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fb_rd_en_q, fb_rd_en_d;
    logic [ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;
    logic              valid_q, valid_d;
    logic              framing_q, framing_d;
    logic              se_frame_q, se_frame_d;
    logic [4:0]        dat_glo_q, dat_glo_d;
    logic [7:0]        dat_red_q, dat_red_d;
    logic [7:0]        dat_grn_q, dat_grn_d;
    logic [7:0]        dat_blu_q, dat_blu_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     eof_cnt_q, eof_cnt_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     n_eof_q, n_eof_d;
    logic [4:0]        g_q, g_d;

    logic              start_go;
    logic [CW-1:0]     n_clamped;
    logic [CW-1:0]     idx_inc;
    logic [CW-1:0]     eof_inc;

`ifdef LEDSTRING_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_DIV > 24'd1) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] refresh_cnt_q;
    logic          refresh_wrap;

    assign refresh_wrap = (refresh_cnt_q == RW'(REFRESH_DIV - 24'd1));

    always_ff @(posedge clk) begin
        if (rst || refresh_wrap) begin
            refresh_cnt_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + RW'(1);
        end
    end

    // A wrap is only acted on in IDLE; nothing remembers a wrap that lands
    // while a frame is busy.
    assign start_go = start | refresh_wrap;
`else
    assign start_go = start;
`endif

    assign n_clamped = (led_count > MAX_N) ? MAX_N : led_count;
    assign idx_inc   = idx_q + CW'(1);
    assign eof_inc   = eof_cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fb_rd_en_d   = 1'b0;
        fb_rd_addr_d = fb_rd_addr_q;
        valid_d      = valid_q;
        framing_d    = framing_q;
        se_frame_d   = se_frame_q;
        dat_glo_d    = dat_glo_q;
        dat_red_d    = dat_red_q;
        dat_grn_d    = dat_grn_q;
        dat_blu_d    = dat_blu_q;
        idx_d        = idx_q;
        eof_cnt_d    = eof_cnt_q;
        n_d          = n_q;
        n_eof_d      = n_eof_q;
        g_d          = g_q;

        // The payload is only rewritten in states where valid is low.
        // That keeps it stable for the whole time a word is offered.
        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    n_d       = n_clamped;
                    n_eof_d   = (n_clamped >> 6) + CW'(1);
                    g_d       = glo;
                    idx_d     = '0;
                    eof_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SOF;
                end
            end
            S_SOF: begin
                framing_d  = 1'b1;
                se_frame_d = 1'b0;
                valid_d    = 1'b1;
                state_d    = S_SOF_W;
            end
            S_SOF_W: begin
                if (ack) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    if (n_q != '0) begin
                        // The read strobe is registered: raising it here
                        // makes it visible for exactly the FETCH cycle.
                        fb_rd_en_d   = 1'b1;
                        fb_rd_addr_d = '0;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_EOF;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                dat_red_d = fb_rd_data[23:16];
                dat_grn_d = fb_rd_data[15:8];
                dat_blu_d = fb_rd_data[7:0];
                dat_glo_d = g_q;
                framing_d = 1'b0;
                valid_d   = 1'b1;
                state_d   = S_PIX_W;
            end
            S_PIX_W: begin
                if (ack) begin
                    valid_d = 1'b0;
                    idx_d   = idx_inc;
                    if (idx_inc == n_q) begin
                        state_d = S_EOF;
                    end else begin
                        fb_rd_en_d   = 1'b1;
                        fb_rd_addr_d = idx_inc[ADDR_W-1:0];
                        state_d      = S_FETCH;
                    end
                end
            end
            S_EOF: begin
                framing_d  = 1'b1;
                se_frame_d = 1'b1;
                valid_d    = 1'b1;
                state_d    = S_EOF_W;
            end
            S_EOF_W: begin
                if (ack) begin
                    valid_d   = 1'b0;
                    eof_cnt_d = eof_inc;
                    if (eof_inc == n_eof_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EOF;
                    end
                end
            end
            S_DONE: begin
                // A start in this cycle is deliberately not looked at.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= '0;
            valid_q      <= 1'b0;
            framing_q    <= 1'b1;
            se_frame_q   <= 1'b0;
            dat_glo_q    <= '0;
            dat_red_q    <= '0;
            dat_grn_q    <= '0;
            dat_blu_q    <= '0;
            idx_q        <= '0;
            eof_cnt_q    <= '0;
            n_q          <= '0;
            n_eof_q      <= '0;
            g_q          <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            valid_q      <= valid_d;
            framing_q    <= framing_d;
            se_frame_q   <= se_frame_d;
            dat_glo_q    <= dat_glo_d;
            dat_red_q    <= dat_red_d;
            dat_grn_q    <= dat_grn_d;
            dat_blu_q    <= dat_blu_d;
            idx_q        <= idx_d;
            eof_cnt_q    <= eof_cnt_d;
            n_q          <= n_d;
            n_eof_q      <= n_eof_d;
            g_q          <= g_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_rd_addr = fb_rd_addr_q;
    assign valid      = valid_q;
    assign framing    = framing_q;
    assign se_frame   = se_frame_q;
    assign dat_glo    = dat_glo_q;
    assign dat_red    = dat_red_q;
    assign dat_grn    = dat_grn_q;
    assign dat_blu    = dat_blu_q;

endmodule

// File: tb/tb_ledstring_fb_streamer.sv
// ============================================================================
// tb_ledstring_fb_streamer
//
// Drives ledstring_fb_streamer with a framebuffer model and an acking sink.
// The sink applies random ack delays. Each frame's word stream and read
// addresses are compared against a list built from the frame rules:
//   - a start frame first,
//   - then pixels mem[0..n-1],
//   - then (n>>6)+1 end frames.
// ============================================================================
`timescale 1ns/1ps
module tb_ledstring_fb_streamer;

    localparam int MAX_LEDS = 256;
    localparam int ADDR_W   = 8;

    typedef struct packed {
        logic        framing;
        logic        se;
        logic [4:0]  g;
        logic [23:0] rgb;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   led_count;
    logic [4:0]        glo;
    logic              busy;
    logic              done;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [23:0]       fb_rd_data;
    logic              framing;
    logic              se_frame;
    logic [4:0]        dat_glo;
    logic [7:0]        dat_red;
    logic [7:0]        dat_grn;
    logic [7:0]        dat_blu;
    logic              valid;
    logic              ack;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:MAX_LEDS-1];
    word_t       words[$];
    int          rd_addrs[$];
    int          done_cnt;
    int          stab_err;
    int          busy_err;
    int          dmin = 0;
    int          dmax = 0;

    always #5 clk = ~clk;

    ledstring_fb_streamer #(
        .MAX_LEDS   (MAX_LEDS),
        .ADDR_W     (ADDR_W),
        .REFRESH_DIV(24'd600000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .led_count (led_count),
        .glo       (glo),
        .busy      (busy),
        .done      (done),
        .fb_rd_en  (fb_rd_en),
        .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data),
        .framing   (framing),
        .se_frame  (se_frame),
        .dat_glo   (dat_glo),
        .dat_red   (dat_red),
        .dat_grn   (dat_grn),
        .dat_blu   (dat_blu),
        .valid     (valid),
        .ack       (ack)
    );

    // Framebuffer model with a 1-cycle read latency.
    // Data is valid only during the cycle after the strobe; otherwise it
    // holds junk.
    initial begin : fb_model
        logic [ADDR_W-1:0] a;
        fb_rd_data = 24'h0;
        forever begin
            @(negedge clk);
            if (fb_rd_en) begin
                a = fb_rd_addr;
                @(posedge clk);
                #1 fb_rd_data = mem[a];
                @(posedge clk);
                #1 fb_rd_data = 24'($urandom);
            end
        end
    end

    // Sink and monitor. It acks each word after a random delay, records
    // accepted words, and logs reads and done pulses. It also flags payload
    // changes while valid is high, and valid appearing without busy.
    initial begin : sink
        int    wc;
        logic  pv;
        word_t held;
        word_t cur;
        ack = 1'b0;
        wc  = 0;
        pv  = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            cur = {framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu};
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (valid && !pv) begin
                    held = cur;
                    wc   = $urandom_range(dmax, dmin);
                end
                if (valid && pv && (cur !== held)) stab_err++;
                if (valid && !busy) busy_err++;
                if (valid) begin
                    if (wc == 0) begin
                        words.push_back(cur);
                        ack = 1'b1;
                    end else begin
                        wc--;
                    end
                end
                if (fb_rd_en) rd_addrs.push_back(int'(fb_rd_addr));
                if (done) done_cnt++;
                pv = valid;
            end
        end
    end

    task automatic run_frame(input int nreq, input logic [4:0] g, input int d0, input int d1,
                             input bit mid_start, input bit coin_start, input string name);
        int    n;
        int    neof;
        int    total;
        int    cyc;
        int    bad;
        bit    got;
        bit    quiet_bad;
        word_t exp;
        word_t act;
        n    = (nreq > MAX_LEDS) ? MAX_LEDS : nreq;
        neof = (n / 64) + 1;
        total = 1 + n + neof;
        dmin = d0;
        dmax = d1;
        words.delete();
        rd_addrs.delete();
        done_cnt = 0;
        stab_err = 0;
        busy_err = 0;

        @(negedge clk);
        led_count = (ADDR_W+1)'(nreq);
        glo       = g;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end

        cyc = 0;
        got = 1'b0;
        while (cyc < 40000 && !got) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            // Changes after the frame has started must not matter.
            if (cyc == 5) begin
                led_count = (ADDR_W+1)'($urandom);
                glo       = 5'($urandom);
            end
            if (mid_start && cyc == 30) start = 1'b1;
            if (done) begin
                got = 1'b1;
                if (coin_start) start = 1'b1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout: got no done in %0d cycles want done", name, cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end

        quiet_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
            if (valid || busy) quiet_bad = 1'b1;
        end
        checks++;
        if (quiet_bad) begin
            errors++;
            $display("FAIL %s idle_after_done: got activity want none", name);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (words.size() != total) begin
            errors++;
            $display("FAIL %s word_count: got %0d want %0d", name, words.size(), total);
        end

        bad = 0;
        for (int i = 0; i < total && i < words.size(); i++) begin
            act = words[i];
            if (i == 0) begin
                exp = '{framing: 1'b1, se: 1'b0, g: 5'h0, rgb: 24'h0};
            end else if (i <= n) begin
                exp = '{framing: 1'b0, se: 1'b0, g: g, rgb: mem[i-1]};
            end else begin
                exp = '{framing: 1'b1, se: 1'b1, g: 5'h0, rgb: 24'h0};
            end
            checks++;
            if (exp.framing) begin
                if ({act.framing, act.se} !== {exp.framing, exp.se}) begin
                    errors++;
                    bad++;
                    $display("FAIL %s word[%0d]: got framing=%b se=%b want framing=%b se=%b",
                             name, i, act.framing, act.se, exp.framing, exp.se);
                end
            end else if ({act.framing, act.g, act.rgb} !== {exp.framing, exp.g, exp.rgb}) begin
                errors++;
                bad++;
                $display("FAIL %s word[%0d]: got f=%b g=%h rgb=%h want f=%b g=%h rgb=%h",
                         name, i, act.framing, act.g, act.rgb, exp.framing, exp.g, exp.rgb);
            end
        end

        checks++;
        if (rd_addrs.size() != n) begin
            errors++;
            $display("FAIL %s read_count: got %0d want %0d", name, rd_addrs.size(), n);
        end
        bad = 0;
        for (int i = 0; i < rd_addrs.size() && i < n; i++) begin
            if (rd_addrs[i] != i) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s read_order: got %0d out-of-order addresses want 0", name, bad);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL %s payload_stable: got %0d changes while valid want 0", name, stab_err);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL %s busy_with_valid: got %0d cycles valid without busy want 0",
                     name, busy_err);
        end
        $display("frame %s n=%0d words=%0d reads=%0d done=%0d", name, n, words.size(),
                 rd_addrs.size(), done_cnt);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        led_count = '0;
        glo       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fb_rd_en, valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy,done,rd_en,valid=%b want 0000",
                     {busy, done, fb_rd_en, valid});
        end
        checks++;
        if (fb_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", fb_rd_addr);
        end
        checks++;
        if ({framing, se_frame} !== 2'b10) begin
            errors++;
            $display("FAIL reset_framing: got %b want 10", {framing, se_frame});
        end
        checks++;
        if ({dat_glo, dat_red, dat_grn, dat_blu} !== 29'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {dat_glo, dat_red, dat_grn, dat_blu});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_start: got busy,valid=%b want 00", {busy, valid});
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        mem[0] = 24'hAA55EE;
        mem[1] = 24'h9944DD;
        mem[2] = 24'h8833CC;
        run_frame(3, 5'h1F, 2, 2, 1'b0, 1'b0, "basic3");
    endtask

    task automatic test_zero();
        run_frame(0, 5'($urandom), 0, 3, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_random_130();
        for (int i = 0; i < MAX_LEDS; i++) mem[i] = 24'($urandom);
        run_frame(130, 5'($urandom), 1, 40, 1'b0, 1'b0, "n130");
    endtask

    task automatic test_max();
        for (int i = 0; i < MAX_LEDS; i++) mem[i] = 24'($urandom);
        run_frame(MAX_LEDS, 5'($urandom), 0, 2, 1'b0, 1'b0, "n256");
        run_frame(int'($urandom_range(511, 257)), 5'($urandom), 0, 1, 1'b0, 1'b0, "clamp");
    endtask

    task automatic test_start_ignored();
        run_frame(20, 5'($urandom), 1, 5, 1'b1, 1'b1, "ignored_starts");
    endtask

    task automatic test_reset_midframe();
        int  cyc;
        bit  seen;
        dmin = 6;
        dmax = 6;
        @(negedge clk);
        led_count = 9'd10;
        glo       = 5'h0A;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (valid && !framing) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_reach_pixel: got no pixel word want one");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_abort: got valid,busy,done=%b want 000", {valid, busy, done});
        end
        rst      = 1'b0;
        done_cnt = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt != 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got done=%0d valid=%b want 0 0", done_cnt, valid);
        end
        $display("reset mid-frame checked");
        run_frame(10, 5'($urandom), 0, 4, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < MAX_LEDS; i++) mem[i] = 24'($urandom);
        test_reset();
        test_basic();
        test_zero();
        test_random_130();
        test_max();
        test_start_ignored();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
